// File: rtl/hdlc_rx_frame_ctrl.sv
// HDLC receive frame controller: opens/closes frames on flag/abort events, streams
// de-stuffed bytes into the Rx buffer and reports frame size and error status.
module hdlc_rx_frame_ctrl #(
    parameter int MAX_BYTES = 128,
    parameter int MIN_BYTES = 4,
    parameter int CNT_W     = 8
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Rx_Enable,
    input  logic             Rx_FlagDetect,
    input  logic             Rx_AbortDetect,
    input  logic             Rx_NewByte,
    input  logic [7:0]       Rx_Data,
    input  logic             Rx_FCSErr,
    input  logic             Rx_ReadDone,
    input  logic             Rx_Drop,
    output logic             Rx_ValidFrame,
    output logic             Rx_WrBuff,
    output logic [CNT_W-1:0] Rx_WrAddr,
    output logic [7:0]       Rx_DataBuff,
    output logic             Rx_EoF,
    output logic             Rx_Ready,
    output logic [CNT_W-1:0] Rx_FrameSize,
    output logic             Rx_FrameError,
    output logic             Rx_Overflow,
    output logic             Rx_AbortSignal
);
    typedef enum logic [1:0] {IDLE, OPEN, FRAME, DONE} state_t;

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_BYTES);
    localparam logic [CNT_W-1:0] MinCnt = CNT_W'(MIN_BYTES);
    localparam logic [CNT_W-1:0] One    = CNT_W'(1);
    localparam logic [CNT_W-1:0] Two    = CNT_W'(2);

    state_t           state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic [CNT_W-1:0] addrNxt, sizeNxt;
    logic [7:0]       dataNxt;
    logic             wrNxt, eofNxt, abortNxt, errNxt, ovfNxt;

    // Both derive directly from the state register, so they already lag the
    // triggering event by one cycle.
    assign Rx_ValidFrame = (state == FRAME);
    assign Rx_Ready      = (state == DONE);

    always_comb begin
        stateNxt = state;
        cntNxt   = cnt;
        wrNxt    = 1'b0;
        addrNxt  = Rx_WrAddr;
        dataNxt  = Rx_DataBuff;
        eofNxt   = 1'b0;
        abortNxt = 1'b0;
        sizeNxt  = Rx_FrameSize;
        errNxt   = Rx_FrameError;
        ovfNxt   = Rx_Overflow;
        case (state)
            IDLE: begin
                if (Rx_Enable && Rx_FlagDetect)
                    stateNxt = OPEN;
            end
            OPEN: begin
                // Repeated flags keep the frame open; a byte together with a flag is dropped.
                if (!Rx_Enable || Rx_AbortDetect || (!Rx_FlagDetect && Rx_Drop)) begin
                    stateNxt = IDLE;
                end else if (!Rx_FlagDetect && Rx_NewByte) begin
                    stateNxt = FRAME;
                    cntNxt   = One;
                    wrNxt    = 1'b1;
                    addrNxt  = '0;
                    dataNxt  = Rx_Data;
                    sizeNxt  = '0;
                    errNxt   = 1'b0;
                    ovfNxt   = 1'b0;
                end
            end
            FRAME: begin
                if (!Rx_Enable) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end else if (Rx_AbortDetect) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                    abortNxt = 1'b1;
                end else if (Rx_FlagDetect) begin
                    stateNxt = DONE;
                    eofNxt   = 1'b1;
                    sizeNxt  = (cnt >= MinCnt) ? cnt - Two : '0;
                    errNxt   = Rx_FCSErr | (cnt < MinCnt);
                end else if (Rx_Drop) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end else if (Rx_NewByte) begin
                    if (cnt < MaxCnt) begin
                        wrNxt   = 1'b1;
                        addrNxt = cnt;
                        dataNxt = Rx_Data;
                        cntNxt  = cnt + One;
                    end else begin
                        ovfNxt  = 1'b1;
                    end
                end
            end
            DONE: begin
                // Held frame survives Rx_Enable=0; only software releases it.
                if (Rx_ReadDone || Rx_Drop) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end
            end
            default: stateNxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst) begin
            state          <= IDLE;
            cnt            <= '0;
            Rx_WrBuff      <= 1'b0;
            Rx_WrAddr      <= '0;
            Rx_DataBuff    <= '0;
            Rx_EoF         <= 1'b0;
            Rx_AbortSignal <= 1'b0;
            Rx_FrameSize   <= '0;
            Rx_FrameError  <= 1'b0;
            Rx_Overflow    <= 1'b0;
        end else begin
            state          <= stateNxt;
            cnt            <= cntNxt;
            Rx_WrBuff      <= wrNxt;
            Rx_WrAddr      <= addrNxt;
            Rx_DataBuff    <= dataNxt;
            Rx_EoF         <= eofNxt;
            Rx_AbortSignal <= abortNxt;
            Rx_FrameSize   <= sizeNxt;
            Rx_FrameError  <= errNxt;
            Rx_Overflow    <= ovfNxt;
        end
    end
endmodule

// File: tb/tb_hdlc_rx_frame_ctrl.sv
// Bench for hdlc_rx_frame_ctrl: directed frame scenarios followed by random line/software
// events, every cycle compared with a queue-based frame model.
module tb_hdlc_rx_frame_ctrl;
    localparam int MAXB = 128;
    localparam int MINB = 4;
    localparam int W    = 8;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic         Rst, Rx_Enable, Rx_FlagDetect, Rx_AbortDetect, Rx_NewByte;
    logic [7:0]   Rx_Data;
    logic         Rx_FCSErr, Rx_ReadDone, Rx_Drop;
    logic         Rx_ValidFrame, Rx_WrBuff, Rx_EoF, Rx_Ready;
    logic [W-1:0] Rx_WrAddr, Rx_FrameSize;
    logic [7:0]   Rx_DataBuff;
    logic         Rx_FrameError, Rx_Overflow, Rx_AbortSignal;

    hdlc_rx_frame_ctrl #(.MAX_BYTES(MAXB), .MIN_BYTES(MINB), .CNT_W(W)) dut (
        .Clk(Clk), .Rst(Rst), .Rx_Enable(Rx_Enable), .Rx_FlagDetect(Rx_FlagDetect),
        .Rx_AbortDetect(Rx_AbortDetect), .Rx_NewByte(Rx_NewByte), .Rx_Data(Rx_Data),
        .Rx_FCSErr(Rx_FCSErr), .Rx_ReadDone(Rx_ReadDone), .Rx_Drop(Rx_Drop),
        .Rx_ValidFrame(Rx_ValidFrame), .Rx_WrBuff(Rx_WrBuff), .Rx_WrAddr(Rx_WrAddr),
        .Rx_DataBuff(Rx_DataBuff), .Rx_EoF(Rx_EoF), .Rx_Ready(Rx_Ready),
        .Rx_FrameSize(Rx_FrameSize), .Rx_FrameError(Rx_FrameError),
        .Rx_Overflow(Rx_Overflow), .Rx_AbortSignal(Rx_AbortSignal)
    );

    int total = 0;
    int bad   = 0;
    int wrCnt = 0;

    // Model: a flag has opened a frame, bytes collected so far, frame held for software.
    bit         mOpen, mHeld;
    logic [7:0] mQ[$];
    logic       eWr, eEoF, eAbort, eErr, eOvf;
    logic [7:0] eAddr, eData, eSize;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic model();
        int n;
        eWr = 1'b0; eEoF = 1'b0; eAbort = 1'b0;
        if (!Rst) begin
            mOpen = 0; mHeld = 0; mQ.delete();
            eSize = '0; eErr = 1'b0; eOvf = 1'b0;
        end else if (mHeld) begin
            if (Rx_ReadDone || Rx_Drop) mHeld = 0;
        end else if (mOpen) begin
            n = mQ.size();
            if (!Rx_Enable) begin
                mOpen = 0; mQ.delete();
            end else if (Rx_AbortDetect) begin
                eAbort = (n > 0);
                mOpen = 0; mQ.delete();
            end else if (Rx_FlagDetect) begin
                if (n > 0) begin
                    eEoF  = 1'b1;
                    eSize = (n >= MINB) ? 8'(n - 2) : 8'd0;
                    eErr  = Rx_FCSErr || (n < MINB);
                    mHeld = 1; mOpen = 0; mQ.delete();
                end
            end else if (Rx_Drop) begin
                mOpen = 0; mQ.delete();
            end else if (Rx_NewByte) begin
                if (n == 0) begin
                    eSize = '0; eErr = 1'b0; eOvf = 1'b0;
                end
                if (n < MAXB) begin
                    eWr = 1'b1; eAddr = 8'(n); eData = Rx_Data;
                    mQ.push_back(Rx_Data);
                end else begin
                    eOvf = 1'b1;
                end
            end
        end else if (Rx_Enable && Rx_FlagDetect) begin
            mOpen = 1;
        end
    endtask

    task automatic check_outs();
        chk("valid", 32'(Rx_ValidFrame), 32'(mOpen && mQ.size() != 0));
        chk("wr", 32'(Rx_WrBuff), 32'(eWr));
        if (eWr) begin
            chk("addr", 32'(Rx_WrAddr), 32'(eAddr));
            chk("data", 32'(Rx_DataBuff), 32'(eData));
        end
        chk("eof", 32'(Rx_EoF), 32'(eEoF));
        chk("ready", 32'(Rx_Ready), 32'(mHeld));
        chk("size", 32'(Rx_FrameSize), 32'(eSize));
        chk("ferr", 32'(Rx_FrameError), 32'(eErr));
        chk("ovf", 32'(Rx_Overflow), 32'(eOvf));
        chk("abort", 32'(Rx_AbortSignal), 32'(eAbort));
        if (Rx_WrBuff === 1'b1) wrCnt++;
    endtask

    task automatic cyc(input bit rst, input bit en, input bit f, input bit a, input bit n,
                       input logic [7:0] d, input bit fcs, input bit rd, input bit dr);
        Rst = rst; Rx_Enable = en; Rx_FlagDetect = f; Rx_AbortDetect = a;
        Rx_NewByte = n; Rx_Data = d; Rx_FCSErr = fcs; Rx_ReadDone = rd; Rx_Drop = dr;
        model();
        @(posedge Clk);
        #1;
        check_outs();
    endtask

    task automatic flag(input bit fcs);  cyc(1, 1, 1, 0, 0, 8'h00, fcs, 0, 0); endtask
    task automatic nbyte(input logic [7:0] d); cyc(1, 1, 0, 0, 1, d, 0, 0, 0); endtask
    task automatic abort();              cyc(1, 1, 0, 1, 0, 8'h00, 0, 0, 0); endtask
    task automatic rdone();              cyc(1, 1, 0, 0, 0, 8'h00, 0, 1, 0); endtask
    task automatic quiet();              cyc(1, 1, 0, 0, 0, 8'h00, 0, 0, 0); endtask

    initial begin
        logic [7:0] t1 [4];
        t1 = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset state
        cyc(0, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        cyc(0, 1, 1, 0, 1, 8'hAA, 0, 0, 0);
        chk("rst ready", 32'(Rx_Ready), 32'd0);
        chk("rst size", 32'(Rx_FrameSize), 32'd0);
        quiet();

        // 1: basic 4-byte frame
        flag(0);
        for (int i = 0; i < 4; i++) begin
            nbyte(t1[i]);
            chk("t1 addr", 32'(Rx_WrAddr), 32'(i));
            chk("t1 data", 32'(Rx_DataBuff), 32'(t1[i]));
        end
        flag(0);
        chk("t1 eof", 32'(Rx_EoF), 32'd1);
        chk("t1 size", 32'(Rx_FrameSize), 32'd2);
        chk("t1 ferr", 32'(Rx_FrameError), 32'd0);
        chk("t1 ready", 32'(Rx_Ready), 32'd1);
        nbyte(8'h55);
        chk("t1 held nowr", 32'(Rx_WrBuff), 32'd0);
        rdone();

        // 2: abort after 10 bytes
        flag(0);
        for (int i = 0; i < 10; i++) nbyte(8'(i + 1));
        abort();
        chk("t2 abort", 32'(Rx_AbortSignal), 32'd1);
        chk("t2 valid", 32'(Rx_ValidFrame), 32'd0);
        chk("t2 ready", 32'(Rx_Ready), 32'd0);
        quiet();
        chk("t2 abort pulse", 32'(Rx_AbortSignal), 32'd0);

        // 3: overflow
        flag(0);
        wrCnt = 0;
        for (int i = 0; i < 130; i++) nbyte(8'($urandom));
        chk("t3 ovf", 32'(Rx_Overflow), 32'd1);
        flag(0);
        chk("t3 writes", 32'(wrCnt), 32'd128);
        chk("t3 size", 32'(Rx_FrameSize), 32'd126);
        chk("t3 ovf held", 32'(Rx_Overflow), 32'd1);
        rdone();
        flag(0);
        nbyte(8'h01);
        chk("t3 ovf clr", 32'(Rx_Overflow), 32'd0);
        abort();

        // 4: runt frame, then idle ignores bytes
        flag(0);
        nbyte(8'hA1);
        nbyte(8'hA2);
        flag(0);
        chk("t4 ferr", 32'(Rx_FrameError), 32'd1);
        chk("t4 size", 32'(Rx_FrameSize), 32'd0);
        rdone();
        chk("t4 ready", 32'(Rx_Ready), 32'd0);
        nbyte(8'hA3);
        chk("t4 idle nowr", 32'(Rx_WrBuff), 32'd0);

        // 5: flag and abort together
        flag(0);
        nbyte(8'hB0);
        cyc(1, 1, 1, 1, 0, 8'h00, 0, 0, 0);
        chk("t5 abort", 32'(Rx_AbortSignal), 32'd1);
        chk("t5 eof", 32'(Rx_EoF), 32'd0);

        // 6: reset mid-frame
        flag(0);
        for (int i = 0; i < 5; i++) nbyte(8'(8'hC0 + i));
        cyc(0, 1, 0, 0, 1, 8'hCC, 0, 0, 0);
        chk("t6 valid", 32'(Rx_ValidFrame), 32'd0);
        chk("t6 wr", 32'(Rx_WrBuff), 32'd0);
        flag(0);
        nbyte(8'hD0);
        chk("t6 addr", 32'(Rx_WrAddr), 32'd0);
        chk("t6 wr1", 32'(Rx_WrBuff), 32'd1);

        // Held frame survives Rx_Enable=0
        for (int i = 0; i < 4; i++) nbyte(8'(i));
        flag(1);
        chk("en ferr", 32'(Rx_FrameError), 32'd1);
        cyc(1, 0, 0, 0, 0, 8'h00, 0, 0, 0);
        chk("en ready", 32'(Rx_Ready), 32'd1);
        rdone();

        // Random events against the model
        for (int i = 0; i < 4000; i++) begin
            cyc($urandom_range(0, 999) >= 3, $urandom_range(0, 99) != 0,
                $urandom_range(0, 99) < 5, $urandom_range(0, 99) < 2,
                $urandom_range(0, 99) < 45, 8'($urandom),
                $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6,
                $urandom_range(0, 99) < 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
